// File: rtl/rm_lane_driver.sv
// rm_lane_driver
//   Queues event requests and replays each one as a single-cycle pulse on a
//   per-event, per-lane vector that feeds a bank of monitors. It also drives
//   timed per-lane reset pulses into those monitors.
//
// Ports
//   clk_i          rising-edge clock for all state
//   rst_ni         asynchronous active-low reset
//   evt_valid_i    event request valid
//   evt_ready_o    request accepted when valid & ready at a clock edge
//   evt_id_i       event class of the request
//   evt_lanes_i    lanes that receive the event pulse
//   flush_i        lane-reset request, sampled each cycle
//   flush_lanes_i  lanes to reset
//   lane_vector_o  registered event pulses, [event][lane]
//   lane_reset_o   registered per-lane reset
//   drop_cnt_o     saturating count of malformed requests
//   busy_o         queue non-empty or a lane reset is in progress
module rm_lane_driver #(
    parameter int NUM_LANES  = 5,
    parameter int NUM_EVENTS = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int RST_CYCLES = 2
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  evt_valid_i,
    output logic                                  evt_ready_o,
    input  logic [$clog2(NUM_EVENTS)-1:0]         evt_id_i,
    input  logic [NUM_LANES-1:0]                  evt_lanes_i,
    input  logic                                  flush_i,
    input  logic [NUM_LANES-1:0]                  flush_lanes_i,
    output logic [NUM_EVENTS-1:0][NUM_LANES-1:0]  lane_vector_o,
    output logic [NUM_LANES-1:0]                  lane_reset_o,
    output logic [15:0]                           drop_cnt_o,
    output logic                                  busy_o
);

    localparam int ID_W  = $clog2(NUM_EVENTS);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;
    localparam int CNT_W = $clog2(RST_CYCLES + 1);

    localparam logic [ID_W:0]      NUM_EVENTS_W = (ID_W + 1)'(NUM_EVENTS);
    localparam logic [CNT_W-1:0]   CNT_RELOAD   = CNT_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
    localparam logic [PW-1:0]      PTR_ONE      = PW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic [ID_W-1:0]      id;
        logic [NUM_LANES-1:0] lanes;
    } entry_t;

    state_t                               state_reg, state_next;
    logic [PW-1:0]                        wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]                        rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]                     cnt_reg, cnt_next;
    logic [NUM_LANES-1:0]                 lane_reset_reg, lane_reset_next;
    logic [NUM_EVENTS-1:0][NUM_LANES-1:0] lane_vector_reg, lane_vector_next;
    logic [15:0]                          drop_cnt_reg;
    logic                                 ready_reg;

    entry_t mem_reg [FIFO_DEPTH];
    entry_t head_entry;

    logic [PW-1:0] count;
    logic          empty;
    logic          full_next;
    logic          accept;
    logic          evt_bad;
    logic          push;
    logic          pop;
    logic          remain;

    // ---------------------------------------------------------------
    // Request side
    // ---------------------------------------------------------------
    assign accept  = evt_valid_i & ready_reg;
    assign evt_bad = ({1'b0, evt_id_i} >= NUM_EVENTS_W) || (evt_lanes_i == '0);
    assign push    = accept & ~evt_bad;

    // ---------------------------------------------------------------
    // FIFO bookkeeping; the extra pointer bit separates full from empty
    // ---------------------------------------------------------------
    assign count       = wr_ptr_reg - rd_ptr_reg;
    assign empty       = (wr_ptr_reg == rd_ptr_reg);
    assign pop         = (state_reg == ST_RUN) && !empty;
    assign head_entry  = mem_reg[rd_ptr_reg[AW-1:0]];
    assign wr_ptr_next = wr_ptr_reg + {{(PW-1){1'b0}}, push};
    assign rd_ptr_next = rd_ptr_reg + {{(PW-1){1'b0}}, pop};
    assign full_next   = (wr_ptr_next[AW] != rd_ptr_next[AW]) &&
                         (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);

    // Entries left after this cycle's pop, ignoring this cycle's push. An
    // entry pushed into an otherwise drained queue waits one cycle in IDLE,
    // which keeps the accept-to-pulse latency at two cycles.
    assign remain = pop ? (count != PTR_ONE) : !empty;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_reg[wr_ptr_reg[AW-1:0]] <= {evt_id_i, evt_lanes_i};
        end
    end

    // ---------------------------------------------------------------
    // Pulse decode: one row per event class
    // ---------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_EVENTS; gi++) begin : g_decode
            assign lane_vector_next[gi] =
                (pop && (head_entry.id == ID_W'(gi))) ? head_entry.lanes : '0;
        end
    endgenerate

    // ---------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        lane_reset_next = lane_reset_reg;
        unique case (state_reg)
            ST_IDLE, ST_RUN: begin
                // A pop in this cycle still completes; flush takes over next.
                if (flush_i) begin
                    state_next      = ST_FLUSH;
                    cnt_next        = CNT_RELOAD;
                    lane_reset_next = flush_lanes_i;
                end else begin
                    state_next = remain ? ST_RUN : ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (flush_i) begin
                    // Re-flush widens the active mask and restarts the timer.
                    cnt_next        = CNT_RELOAD;
                    lane_reset_next = lane_reset_reg | flush_lanes_i;
                end else if (cnt_reg == CNT_ONE) begin
                    state_next      = empty ? ST_IDLE : ST_RUN;
                    cnt_next        = '0;
                    lane_reset_next = '0;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            default: begin
                state_next      = ST_IDLE;
                cnt_next        = '0;
                lane_reset_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg       <= ST_IDLE;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            cnt_reg         <= '0;
            lane_reset_reg  <= '0;
            lane_vector_reg <= '0;
            drop_cnt_reg    <= '0;
            ready_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wr_ptr_reg      <= wr_ptr_next;
            rd_ptr_reg      <= rd_ptr_next;
            cnt_reg         <= cnt_next;
            lane_reset_reg  <= lane_reset_next;
            lane_vector_reg <= lane_vector_next;
            // Ready tracks the post-edge fullness, so a pop never frees a
            // slot for a push in the same cycle.
            ready_reg       <= !full_next;
            if (accept && evt_bad && (drop_cnt_reg != 16'hFFFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
        end
    end

    assign evt_ready_o   = ready_reg;
    assign lane_vector_o = lane_vector_reg;
    assign lane_reset_o  = lane_reset_reg;
    assign drop_cnt_o    = drop_cnt_reg;
    assign busy_o        = !empty || (state_reg == ST_FLUSH);

endmodule

// File: tb/tb_rm_lane_driver.sv
// Bench for rm_lane_driver: directed stimulus, with expected pulses queued
// at acceptance and compared by an independent monitor.
module tb_rm_lane_driver;

    localparam int NL   = 5;
    localparam int NE   = 10;
    localparam int ID_W = $clog2(NE);
    localparam int VW   = NE * NL;

    typedef logic [VW-1:0] vec_t;

    logic                  clk = 1'b0;
    logic                  rst_ni;
    logic                  evt_valid;
    logic                  evt_ready;
    logic [ID_W-1:0]       evt_id;
    logic [NL-1:0]         evt_lanes;
    logic                  flush;
    logic [NL-1:0]         flush_lanes;
    logic [NE-1:0][NL-1:0] lane_vector;
    logic [NL-1:0]         lane_reset;
    logic [15:0]           drop_cnt;
    logic                  busy;

    int   errors   = 0;
    int   checks   = 0;
    int   seen_cnt = 0;
    vec_t sb[$];
    vec_t mon_exp;

    rm_lane_driver #(
        .NUM_LANES (NL),
        .NUM_EVENTS(NE),
        .FIFO_DEPTH(4),
        .RST_CYCLES(2)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .evt_valid_i  (evt_valid),
        .evt_ready_o  (evt_ready),
        .evt_id_i     (evt_id),
        .evt_lanes_i  (evt_lanes),
        .flush_i      (flush),
        .flush_lanes_i(flush_lanes),
        .lane_vector_o(lane_vector),
        .lane_reset_o (lane_reset),
        .drop_cnt_o   (drop_cnt),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    function automatic vec_t mkvec(input int id, input logic [NL-1:0] lanes);
        vec_t v;
        v = '0;
        v[id*NL +: NL] = lanes;
        return v;
    endfunction

    // Monitor: every non-zero pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_ni && (lane_vector != '0)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got %0h expected none", lane_vector);
            end else begin
                mon_exp = sb.pop_front();
                check("pulse", lane_vector, mon_exp);
                seen_cnt++;
            end
        end
    end

    // Issue one request and hold it until accepted (bounded wait).
    task automatic send(input int id, input logic [NL-1:0] lanes, input bit good);
        bit acc;
        acc       = 1'b0;
        evt_valid = 1'b1;
        evt_id    = id[ID_W-1:0];
        evt_lanes = lanes;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = evt_ready;
            if (acc && good) sb.push_back(mkvec(id, lanes));
            @(posedge clk);
            #1;
        end
        evt_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got not-accepted expected accepted (id=%0d)", id);
        end
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!busy && sb.size() == 0) break;
        end
        check("drain_sb_empty", 64'(sb.size()), 64'd0);
        check("drain_busy", busy, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_ni      = 1'b0;
        evt_valid   = 1'b0;
        evt_id      = '0;
        evt_lanes   = '0;
        flush       = 1'b0;
        flush_lanes = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_lane_vector", lane_vector, '0);
        check("rst_lane_reset", lane_reset, '0);
        check("rst_drop_cnt", drop_cnt, 16'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", evt_ready, 1'b0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ready_after_reset", evt_ready, 1'b1);

        // Single event, two-cycle latency
        @(posedge clk); #1;
        evt_valid = 1'b1; evt_id = 4'd3; evt_lanes = 5'b00101;
        sb.push_back(mkvec(3, 5'b00101));
        @(posedge clk); #1;                  // edge N accepts
        evt_valid = 1'b0;
        @(negedge clk);
        check("lat_n0", lane_vector, '0);
        check("lat_busy", busy, 1'b1);
        @(negedge clk);
        check("lat_n1", lane_vector, '0);
        @(negedge clk);
        check("lat_n2_row3", lane_vector[3], 5'b00101);
        @(negedge clk);
        check("lat_n3", lane_vector, '0);

        // Backpressure with dispatch held off by a sustained flush
        @(posedge clk); #1;
        flush = 1'b1; flush_lanes = 5'b00001;
        send(1, 5'b00001, 1'b1);
        send(2, 5'b00010, 1'b1);
        send(4, 5'b00100, 1'b1);
        send(9, 5'b11111, 1'b1);
        @(negedge clk);
        check("bp_full_ready", evt_ready, 1'b0);
        check("bp_lane_reset", lane_reset, 5'b00001);
        flush = 1'b0;
        base = seen_cnt;
        send(0, 5'b10000, 1'b1);
        check("bp_pop_before_5th", 64'(seen_cnt - base >= 1), 64'd1);
        wait_drain();
        check("bp_reset_clear", lane_reset, '0);

        // Drops: bad id and empty mask, then saturation
        @(posedge clk); #1;
        send(12, 5'b00001, 1'b0);
        send(5, 5'b00000, 1'b0);
        @(negedge clk);
        check("drop_two", drop_cnt, 16'd2);
        @(posedge clk); #1;
        evt_valid = 1'b1; evt_id = 4'd12; evt_lanes = 5'b00001;
        repeat (65532) @(posedge clk);
        #1;
        check("drop_fffe", drop_cnt, 16'hFFFE);
        @(posedge clk); #1;
        check("drop_ffff", drop_cnt, 16'hFFFF);
        repeat (70000 - 65535) @(posedge clk);
        #1;
        evt_valid = 1'b0;
        check("drop_saturated", drop_cnt, 16'hFFFF);

        // Flush timing and re-flush widening
        @(posedge clk); #1;
        flush = 1'b1; flush_lanes = 5'b10000;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_c1", lane_reset, 5'b10000);
        check("flush_busy", busy, 1'b1);
        @(posedge clk); #1;
        flush = 1'b1; flush_lanes = 5'b00001;
        @(negedge clk);
        check("flush_c2", lane_reset, 5'b10000);
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_c3", lane_reset, 5'b10001);
        @(negedge clk);
        check("flush_c4", lane_reset, 5'b10001);
        @(negedge clk);
        check("flush_done", lane_reset, 5'b00000);
        check("flush_idle", busy, 1'b0);

        // Reset mid-operation with three queued events
        @(posedge clk); #1;
        flush = 1'b1; flush_lanes = 5'b00010;
        send(6, 5'b01000, 1'b1);
        send(7, 5'b00110, 1'b1);
        send(8, 5'b10001, 1'b1);
        rst_ni = 1'b0;
        flush  = 1'b0;
        sb.delete();
        @(negedge clk);
        check("mid_rst_vector", lane_vector, '0);
        check("mid_rst_lane_reset", lane_reset, '0);
        check("mid_rst_drop", drop_cnt, 16'h0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", evt_ready, 1'b0);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_ready_after", evt_ready, 1'b1);
        check("mid_rst_busy_after", busy, 1'b0);
        repeat (10) @(negedge clk);
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rm_lane_driver.md
RM_LANE_DRIVER -- requirements
Module: rm_lane_driver

Interface
REQ-001 SHALL have parameter NUM_LANES, default 5, number of monitor lanes driven.
REQ-002 SHALL have parameter NUM_EVENTS, default 10, number of event classes per lane.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, event queue entries (power of two, >=2).
REQ-004 SHALL have parameter RST_CYCLES, default 2, lane-reset pulse length in cycles (>=1).
REQ-005 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port evt_valid_i  input  1  event request valid.
REQ-008 SHALL have port evt_ready_o  output  1  event request accepted when valid&ready at clock edge.
REQ-009 SHALL have port evt_id_i  input  $clog2(NUM_EVENTS)  event class.
REQ-010 SHALL have port evt_lanes_i  input  NUM_LANES  target lane mask.
REQ-011 SHALL have port flush_i  input  1  lane-reset request, single-cycle sampled.
REQ-012 SHALL have port flush_lanes_i  input  NUM_LANES  lanes to reset.
REQ-013 SHALL have port lane_vector_o  output  [NUM_EVENTS][NUM_LANES]  registered event pulses to monitor.
REQ-014 SHALL have port lane_reset_o  output  NUM_LANES  registered per-lane reset to monitor.
REQ-015 SHALL have port drop_cnt_o  output  16  count of dropped requests.
REQ-016 SHALL have port busy_o  output  1  high when FIFO non-empty or state FLUSH.

Function
REQ-017 SHALL accept an event when evt_valid_i&evt_ready_o; evt_ready_o = FIFO not full (no same-cycle pop bypass).
REQ-018 SHALL drop, not enqueue, an accepted event with evt_id_i>=NUM_EVENTS or evt_lanes_i==0, incrementing drop_cnt_o by 1, saturating at 0xFFFF.
REQ-019 SHALL implement FSM states IDLE (FIFO empty), RUN (FIFO non-empty, dispatching), FLUSH (lane reset active).
REQ-020 SHALL in RUN pop one entry per cycle and set lane_vector_o[id][l]=1 for each l in the entry mask for exactly one cycle; all other bits 0.
REQ-021 SHALL give 2-cycle latency: event accepted at edge N into empty FIFO in IDLE -> lane_vector_o pulse visible after edge N+2; sustained throughput 1 event/cycle.
REQ-022 SHALL preserve FIFO order; two consecutive events produce pulses on consecutive cycles.
REQ-023 SHALL on flush_i=1 enter FLUSH at next edge from any state, drive lane_reset_o=flush_lanes_i for RST_CYCLES cycles, then return to RUN if FIFO non-empty else IDLE.
REQ-024 SHALL give flush priority over dispatch: no pop and lane_vector_o=0 while in FLUSH; an entry not yet popped stays queued.
REQ-025 SHALL on flush_i during FLUSH OR flush_lanes_i into the active mask and reload the cycle counter to RST_CYCLES.
REQ-026 SHALL keep accepting events during FLUSH while FIFO not full.
REQ-027 SHALL on simultaneous flush_i and RUN pop in the same cycle complete that pop (pulse issued), then enter FLUSH.
REQ-028 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH with distinct full/empty detection (extra pointer bit).

Reset
REQ-029 SHALL while rst_ni=0 asynchronously force: state IDLE, FIFO empty, lane_vector_o=0, lane_reset_o=0, drop_cnt_o=0, busy_o=0, evt_ready_o=0.
REQ-030 SHALL assert evt_ready_o=1 on the first cycle after rst_ni deasserts; reset mid-operation discards queued events and any flush in progress.

Verification
REQ-031 SHALL verify single event: id=3, lanes=5'b00101 accepted at edge N -> lane_vector_o[3]=5'b00101 for one cycle after edge N+2, else 0.
REQ-032 SHALL verify backpressure: 5 events back-to-back with dispatch blocked by flush -> evt_ready_o=0 after 4 accepted; 5th accepted after first pop; all 5 pulses in order.
REQ-033 SHALL verify drops: id=12 and lanes=0 each sent once -> drop_cnt_o=2, no lane_vector_o activity; 70000 drops -> drop_cnt_o=0xFFFF.
REQ-034 SHALL verify flush: flush_i, lanes=5'b10000, RST_CYCLES=2 -> lane_reset_o=5'b10000 for exactly 2 cycles; second flush lanes=5'b00001 on its 2nd cycle -> 5'b10001 for 2 further cycles.
REQ-035 SHALL verify reset mid-operation: 3 queued events, rst_ni low for 1 cycle -> all outputs 0, no pulses afterwards, evt_ready_o=1 next cycle.
